// File: rtl/autoconfig_multi_pkg.sv
// Shared Zorro III bus encodings, AutoConfig register offsets and local FSM types.
package autoconfig_multi_pkg;

  typedef enum logic [1:0] {
    Z3_IDLE = 2'd0,
    Z3_ADDR = 2'd1,
    Z3_DATA = 2'd2,
    Z3_END  = 2'd3
  } z3_state_t;

  localparam logic [5:0] REG_BASE_HI = 6'h11;
  localparam logic [5:0] REG_BASE_LO = 6'h12;
  localparam logic [5:0] REG_SHUTUP  = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } ac_state_t;

  // Zorro III puts the nibble-select bit above the register offset bits.
  function automatic logic [6:0] nibble_index(input logic [6:0] addrl);
    return {addrl[5:0], addrl[6]};
  endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig nibble lookup for one logical board; most fields are stored inverted.
module autoconfig_rom #(
  parameter int                        NUM_BOARDS = 2,
  parameter int                        BRD_W      = 2,
  parameter logic [15:0]               MFG_ID     = 16'h07DB,
  parameter logic [NUM_BOARDS*8-1:0]   PROD_IDS   = {8'h73, 8'h72},
  parameter logic [NUM_BOARDS*4-1:0]   SIZE_CODES = {4'b0100, 4'b0100},
  parameter logic [31:0]               SERIAL     = 32'd421
) (
  input  logic [BRD_W-1:0] board,
  input  logic [6:0]       idx,
  output logic [3:0]       nibble
);

  logic [7:0]  prod;
  logic [3:0]  size;
  logic [31:0] serial;

  always_comb begin
    prod = 8'h00;
    size = 4'h0;
    for (int k = 0; k < NUM_BOARDS; k++) begin
      if (board == BRD_W'(k)) begin
        prod = PROD_IDS[k*8 +: 8];
        size = SIZE_CODES[k*4 +: 4];
      end
    end
    serial = SERIAL + 32'(board);
  end

  always_comb begin
    nibble = 4'hF;
    case (idx)
      7'h00: nibble = 4'b1010;
      7'h01: nibble = size;
      7'h02: nibble = ~prod[7:4];
      7'h03: nibble = ~prod[3:0];
      7'h04: nibble = ~4'b1011;
      7'h05: nibble = ~4'b0001;
      7'h08: nibble = ~MFG_ID[15:12];
      7'h09: nibble = ~MFG_ID[11:8];
      7'h0A: nibble = ~MFG_ID[7:4];
      7'h0B: nibble = ~MFG_ID[3:0];
      7'h0C: nibble = ~serial[31:28];
      7'h0D: nibble = ~serial[27:24];
      7'h0E: nibble = ~serial[23:20];
      7'h0F: nibble = ~serial[19:16];
      7'h10: nibble = ~serial[15:12];
      7'h11: nibble = ~serial[11:8];
      7'h12: nibble = ~serial[7:4];
      7'h13: nibble = ~serial[3:0];
      7'h20: nibble = 4'h0;
      7'h21: nibble = 4'h0;
      default: nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_multi.sv
// Zorro III AutoConfig responder presenting NUM_BOARDS logical boards one after another
// on a single configuration slot; CFGOUT_n drops once every board is configured or shut up.
module autoconfig_multi
  import autoconfig_multi_pkg::*;
#(
  parameter int                        NUM_BOARDS = 2,
  parameter int                        BASE_BITS  = 4,
  parameter logic [15:0]               MFG_ID     = 16'h07DB,
  parameter logic [NUM_BOARDS*8-1:0]   PROD_IDS   = {8'h73, 8'h72},
  parameter logic [NUM_BOARDS*4-1:0]   SIZE_CODES = {4'b0100, 4'b0100},
  parameter logic [31:0]               SERIAL     = 32'd421
) (
  input  logic                            CLK,
  input  logic                            RESET_n,
  input  logic                            autoconfig_cycle,
  input  logic [6:0]                      ADDRL,
  input  logic                            FCS_n,
  input  logic                            READ,
  input  logic [3:0]                      DIN,
  input  logic [1:0]                      z3_state,
  output logic [3:0]                      DOUT,
  output logic                            dtack,
  output logic                            CFGOUT_n,
  output logic [NUM_BOARDS-1:0]           configured,
  output logic [NUM_BOARDS-1:0]           shutup,
  output logic [NUM_BOARDS*BASE_BITS-1:0] base_addr
);

  localparam int                CUR_W    = $clog2(NUM_BOARDS + 1);
  localparam logic [CUR_W-1:0]  DONE_IDX = CUR_W'(NUM_BOARDS);

  ac_state_t            state_reg;
  logic [CUR_W-1:0]     cur_reg;
  logic [3:0]           dout_reg;
  logic                 dtack_reg;
  logic                 armed_reg;
  logic                 fcs_n_prev_reg;
  logic                 cfgout_n_reg;

  logic                 bus_active;
  logic                 all_done;
  logic                 do_access;
  logic                 wr_access;
  logic                 wr_shutup;
  logic                 wr_commit;
  logic                 advance;
  logic [6:0]           rom_idx;
  logic [3:0]           rom_nibble;
  logic [BASE_BITS-1:0] commit_value;

  assign bus_active = (z3_state == Z3_DATA) && autoconfig_cycle;
  assign all_done   = (cur_reg == DONE_IDX);
  // armed_reg requires an idle edge first, so a phase straddling reset is never serviced.
  assign do_access  = (state_reg == ST_IDLE) && bus_active && armed_reg && !all_done;
  assign wr_access  = do_access && !READ;
  assign wr_shutup  = wr_access && (ADDRL[5:0] == REG_SHUTUP);
  assign wr_commit  = wr_access && (ADDRL[5:0] == REG_BASE_HI);
  assign advance    = wr_shutup || wr_commit;
  assign rom_idx    = nibble_index(ADDRL);

  autoconfig_rom #(
    .NUM_BOARDS (NUM_BOARDS),
    .BRD_W      (CUR_W),
    .MFG_ID     (MFG_ID),
    .PROD_IDS   (PROD_IDS),
    .SIZE_CODES (SIZE_CODES),
    .SERIAL     (SERIAL)
  ) u_rom (
    .board  (cur_reg),
    .idx    (rom_idx),
    .nibble (rom_nibble)
  );

  generate
    if (BASE_BITS == 8) begin : g_stage8
      logic [3:0] staged_reg;
      logic       wr_stage;

      assign wr_stage = wr_access && (ADDRL[5:0] == REG_BASE_LO);

      // Cleared on every advance so the next board never inherits a stale low nibble.
      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          staged_reg <= 4'h0;
        end else if (advance) begin
          staged_reg <= 4'h0;
        end else if (wr_stage) begin
          staged_reg <= DIN;
        end
      end

      assign commit_value = {DIN, staged_reg};
    end else begin : g_stage4
      assign commit_value = DIN;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BOARDS; gi++) begin : g_board
      localparam logic [CUR_W-1:0] MY_IDX = CUR_W'(gi);
      logic                 cfg_reg;
      logic                 shut_reg;
      logic [BASE_BITS-1:0] base_reg;

      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          cfg_reg  <= 1'b0;
          shut_reg <= 1'b0;
          base_reg <= '0;
        end else if (cur_reg == MY_IDX) begin
          if (wr_shutup) begin
            shut_reg <= 1'b1;
          end
          if (wr_commit) begin
            cfg_reg  <= 1'b1;
            base_reg <= commit_value;
          end
        end
      end

      assign configured[gi]                         = cfg_reg;
      assign shutup[gi]                             = shut_reg;
      assign base_addr[gi*BASE_BITS +: BASE_BITS]   = base_reg;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg      <= ST_IDLE;
      cur_reg        <= '0;
      dout_reg       <= 4'h0;
      dtack_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      fcs_n_prev_reg <= 1'b1;
      cfgout_n_reg   <= 1'b1;
    end else begin
      armed_reg      <= !bus_active;
      fcs_n_prev_reg <= FCS_n;
      if (FCS_n && !fcs_n_prev_reg) begin
        cfgout_n_reg <= (cur_reg != DONE_IDX);
      end

      case (state_reg)
        ST_IDLE: begin
          if (do_access) begin
            state_reg <= ST_ACK;
            dtack_reg <= 1'b1;
            if (READ) begin
              dout_reg <= rom_nibble;
            end
            if (advance) begin
              cur_reg <= cur_reg + CUR_W'(1);
            end
          end
        end
        ST_ACK: begin
          if (bus_active) begin
            state_reg <= ST_HOLD;
          end else begin
            state_reg <= ST_IDLE;
            dtack_reg <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!bus_active) begin
            state_reg <= ST_IDLE;
            dtack_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          dtack_reg <= 1'b0;
        end
      endcase
    end
  end

  assign DOUT     = dout_reg;
  assign dtack    = dtack_reg;
  assign CFGOUT_n = cfgout_n_reg;

endmodule

// File: tb/tb_autoconfig_multi.sv
// Directed bench: ROM read table on board 0, then configuration, hold, reset and 8-bit base sequences.
module tb_autoconfig_multi;
  import autoconfig_multi_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        acyc = 1'b0;
  logic [6:0]  ADDRL = 7'h00;
  logic        FCS_n = 1'b1;
  logic        READ = 1'b1;
  logic [3:0]  DIN = 4'h0;
  logic [1:0]  z3s = Z3_IDLE;
  logic        which = 1'b0;

  logic [3:0]  dout4, dout8;
  logic        dtack4, dtack8, cfgout4, cfgout8;
  logic [1:0]  configured4, configured8, shutup4, shutup8;
  logic [7:0]  base4;
  logic [15:0] base8;

  logic [3:0]  dout_w;
  logic        dtack_w, cfgout_w;
  logic [1:0]  configured_w, shutup_w;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  autoconfig_multi dut4 (
    .CLK (CLK), .RESET_n (RESET_n), .autoconfig_cycle (acyc && !which), .ADDRL (ADDRL),
    .FCS_n (FCS_n), .READ (READ), .DIN (DIN), .z3_state (z3s), .DOUT (dout4),
    .dtack (dtack4), .CFGOUT_n (cfgout4), .configured (configured4), .shutup (shutup4),
    .base_addr (base4)
  );

  autoconfig_multi #(.BASE_BITS(8)) dut8 (
    .CLK (CLK), .RESET_n (RESET_n), .autoconfig_cycle (acyc && which), .ADDRL (ADDRL),
    .FCS_n (FCS_n), .READ (READ), .DIN (DIN), .z3_state (z3s), .DOUT (dout8),
    .dtack (dtack8), .CFGOUT_n (cfgout8), .configured (configured8), .shutup (shutup8),
    .base_addr (base8)
  );

  assign dout_w       = which ? dout8 : dout4;
  assign dtack_w      = which ? dtack8 : dtack4;
  assign cfgout_w     = which ? cfgout8 : cfgout4;
  assign configured_w = which ? configured8 : configured4;
  assign shutup_w     = which ? shutup8 : shutup4;

  typedef struct packed {
    logic [6:0] idx;
    logic [3:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab [24];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  // One bus cycle started at a negedge; Z3_DATA held for `hold` rising edges.
  task automatic bus_cycle(input logic rd, input logic [6:0] addrl, input logic [3:0] din,
                           input int hold, output logic ack, output logic [3:0] data,
                           output logic drop);
    ADDRL = addrl;
    READ  = rd;
    DIN   = din;
    FCS_n = 1'b0;
    z3s   = Z3_DATA;
    acyc  = 1'b1;
    repeat (hold) @(negedge CLK);
    ack  = dtack_w;
    data = dout_w;
    z3s  = Z3_IDLE;
    acyc = 1'b0;
    FCS_n = 1'b1;
    @(negedge CLK);
    drop = dtack_w;
    @(negedge CLK);
    $display("txn dut%0d %s addrl=%h din=%h hold=%0d ack=%b dout=%h drop=%b",
             which ? 8 : 4, rd ? "rd" : "wr", addrl, din, hold, ack, data, drop);
  endtask

  task automatic rd_idx(input logic [6:0] idx, output logic ack, output logic [3:0] data);
    logic [6:0] a;
    logic       drop;
    a = {idx[0], idx[6:1]};
    bus_cycle(1'b1, a, 4'h0, 1, ack, data, drop);
  endtask

  task automatic wr_reg(input logic [5:0] off, input logic [3:0] din, input int hold,
                        output logic ack, output logic drop);
    logic [3:0] data;
    bus_cycle(1'b0, {1'b0, off}, din, hold, ack, data, drop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, drop;
    logic [3:0] data;

    rd_tab[0]  = '{7'h00, 4'hA};  rd_tab[1]  = '{7'h01, 4'h4};
    rd_tab[2]  = '{7'h02, 4'h8};  rd_tab[3]  = '{7'h03, 4'hD};
    rd_tab[4]  = '{7'h04, 4'h4};  rd_tab[5]  = '{7'h05, 4'hE};
    rd_tab[6]  = '{7'h06, 4'hF};  rd_tab[7]  = '{7'h07, 4'hF};
    rd_tab[8]  = '{7'h08, 4'hF};  rd_tab[9]  = '{7'h09, 4'h8};
    rd_tab[10] = '{7'h0A, 4'h2};  rd_tab[11] = '{7'h0B, 4'h4};
    rd_tab[12] = '{7'h0C, 4'hF};  rd_tab[13] = '{7'h0D, 4'hF};
    rd_tab[14] = '{7'h0E, 4'hF};  rd_tab[15] = '{7'h0F, 4'hF};
    rd_tab[16] = '{7'h10, 4'hF};  rd_tab[17] = '{7'h11, 4'hE};
    rd_tab[18] = '{7'h12, 4'h5};  rd_tab[19] = '{7'h13, 4'hA};
    rd_tab[20] = '{7'h14, 4'hF};  rd_tab[21] = '{7'h20, 4'h0};
    rd_tab[22] = '{7'h21, 4'h0};  rd_tab[23] = '{7'h7F, 4'hF};

    // Reset state, sampled while reset is held
    repeat (3) @(negedge CLK);
    check("rst_dout", 32'(dout4), 32'h0);
    check("rst_dtack", 32'(dtack4), 32'h0);
    check("rst_cfgout", 32'(cfgout4), 32'h1);
    check("rst_configured", 32'(configured4), 32'h0);
    check("rst_shutup", 32'(shutup4), 32'h0);
    check("rst_base", 32'(base4), 32'h0);
    check("rst_base8", 32'(base8), 32'h0);
    RESET_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);

    // Board 0 ROM table
    for (int i = 0; i < 24; i++) begin
      rd_idx(rd_tab[i].idx, ack, data);
      check($sformatf("rom_dout_idx%02h", rd_tab[i].idx), 32'(data), 32'(rd_tab[i].exp));
      check($sformatf("rom_dtack_idx%02h", rd_tab[i].idx), 32'(ack), 32'h1);
    end

    // Configure board 0 with base 4, then board 1 identity
    wr_reg(REG_BASE_HI, 4'h4, 1, ack, drop);
    check("cfg0_ack", 32'(ack), 32'h1);
    check("cfg0_drop", 32'(drop), 32'h0);
    check("cfg0_configured", 32'(configured4), 32'h1);
    check("cfg0_base", 32'(base4), 32'h04);
    wr_reg(6'h20, 4'h9, 1, ack, drop);
    check("other_wr_ack", 32'(ack), 32'h1);
    check("other_wr_configured", 32'(configured4), 32'h1);
    check("other_wr_base", 32'(base4), 32'h04);
    rd_idx(7'h02, ack, data);  check("b1_prod_hi", 32'(data), 32'h8);
    rd_idx(7'h03, ack, data);  check("b1_prod_lo", 32'(data), 32'hC);
    rd_idx(7'h12, ack, data);  check("b1_serial_12", 32'(data), 32'h5);
    rd_idx(7'h13, ack, data);  check("b1_serial_13", 32'(data), 32'h9);
    check("b1_cfgout_pending", 32'(cfgout4), 32'h1);

    // Long data phase: one commit only, dtack drops one clock after the phase ends
    do_reset();
    wr_reg(REG_BASE_HI, 4'h3, 5, ack, drop);
    check("hold_ack", 32'(ack), 32'h1);
    check("hold_drop", 32'(drop), 32'h0);
    check("hold_configured", 32'(configured4), 32'h1);
    check("hold_base", 32'(base4), 32'h03);

    // Shut up board 0, configure board 1, chain output falls
    do_reset();
    wr_reg(REG_SHUTUP, 4'h0, 1, ack, drop);
    check("shut_shutup", 32'(shutup4), 32'h1);
    check("shut_configured", 32'(configured4), 32'h0);
    check("shut_cfgout", 32'(cfgout4), 32'h1);
    wr_reg(REG_BASE_HI, 4'h8, 1, ack, drop);
    check("last_shutup", 32'(shutup4), 32'h1);
    check("last_configured", 32'(configured4), 32'h2);
    check("last_base", 32'(base4), 32'h80);
    check("last_cfgout", 32'(cfgout4), 32'h0);
    rd_idx(7'h00, ack, data);
    check("done_no_ack", 32'(ack), 32'h0);
    check("done_dout_kept", 32'(data), 32'h0);
    check("done_configured_kept", 32'(configured4), 32'h2);

    // Reset asserted in HOLD during a write
    do_reset();
    rd_idx(7'h00, ack, data);
    check("pre_rst_dout", 32'(data), 32'hA);
    ADDRL = {1'b0, REG_BASE_HI};
    READ  = 1'b0;
    DIN   = 4'h5;
    FCS_n = 1'b0;
    z3s   = Z3_DATA;
    acyc  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_dtack_before", 32'(dtack4), 32'h1);
    #2 RESET_n = 1'b0;
    #1;
    check("mid_rst_dtack", 32'(dtack4), 32'h0);
    check("mid_rst_dout", 32'(dout4), 32'h0);
    check("mid_rst_configured", 32'(configured4), 32'h0);
    check("mid_rst_base", 32'(base4), 32'h0);
    check("mid_rst_cfgout", 32'(cfgout4), 32'h1);
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("post_rst_no_ack", 32'(dtack4), 32'h0);
    check("post_rst_configured", 32'(configured4), 32'h0);
    z3s   = Z3_IDLE;
    acyc  = 1'b0;
    FCS_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    rd_idx(7'h02, ack, data);
    check("post_rst_read", 32'(data), 32'h8);
    check("post_rst_read_ack", 32'(ack), 32'h1);

    // 8-bit base: stage low nibble, commit high nibble
    which = 1'b1;
    do_reset();
    wr_reg(REG_BASE_LO, 4'hA, 1, ack, drop);
    check("stage_ack", 32'(ack), 32'h1);
    check("stage_configured", 32'(configured8), 32'h0);
    wr_reg(REG_BASE_HI, 4'h5, 1, ack, drop);
    check("commit_configured", 32'(configured8), 32'h1);
    check("commit_base", 32'(base8), 32'h005A);
    wr_reg(REG_BASE_HI, 4'h7, 1, ack, drop);
    check("commit_nostage_base", 32'(base8), 32'h705A);
    check("commit_nostage_configured", 32'(configured8), 32'h3);
    check("b8_cfgout", 32'(cfgout8), 32'h0);
    rd_idx(7'h00, ack, data);
    check("b8_done_no_ack", 32'(ack), 32'h0);
    check("b8_done_dout", 32'(data), 32'h0);
    check("b8_dut4_untouched", 32'(configured4), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
